// File: rtl/seq_divider.sv
// Iterative non-restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrff_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  logic             w_dz;
  logic             w_last;
  logic [WIDTH-1:0] w_nmag;
  logic [WIDTH-1:0] w_dmag;
  logic [WIDTH:0]   w_pshift;
  logic [WIDTH:0]   w_pnext;
  logic [WIDTH-1:0] w_qnext;
  logic [WIDTH-1:0] w_rmag;
  logic [WIDTH-1:0] w_qres;
  logic [WIDTH-1:0] w_rres;

  assign w_dz   = (divisor == '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_qneg;
  logic r_rneg;
  logic w_nneg;
  logic w_dneg;

  assign w_nneg = dividend[WIDTH-1];
  assign w_dneg = divisor[WIDTH-1];
  assign w_nmag = w_nneg ? -dividend : dividend;
  assign w_dmag = w_dneg ? -divisor : divisor;
`else
  assign w_nmag = dividend;
  assign w_dmag = divisor;
`endif

  // P is kept modulo 2^(WIDTH+1); the true value always lies in [-D, D)
  assign w_pshift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_pnext  = r_p[WIDTH] ? (w_pshift + {1'b0, r_d})
                               : (w_pshift - {1'b0, r_d});
  assign w_qnext  = {r_q[WIDTH-2:0], ~w_pnext[WIDTH]};

  assign w_rmag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d)
                             : r_p[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign w_qres = r_qneg ? -r_q : r_q;
  assign w_rres = r_rneg ? -w_rmag : w_rmag;
`else
  assign w_qres = r_q;
  assign w_rres = w_rmag;
`endif

  always_ff @(posedge clk) begin
    if (!clrff_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_dz ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrff_n) begin
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_p   <= '0;
            r_q   <= w_nmag;
            r_d   <= w_dmag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_qneg <= w_nneg ^ w_dneg;
            r_rneg <= w_nneg;
`endif
            if (w_dz) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_pnext;
          r_q   <= w_qnext;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          quotient  <= w_qres;
          remainder <= w_rres;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
